// File: rtl/uart_cmd_ctrl_pkg.sv
// Shared types and constants for the UART command-frame controller
// (SOF, CMD, LEN, payload, CHK frames).
package uart_cmd_pkg;

    localparam int BYTE_W = 8;
    localparam logic [BYTE_W-1:0] SOF_DEFAULT = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_LEN,
        ST_DATA,
        ST_CHK,
        ST_HOLD
    } state_e;

endpackage

// File: rtl/uart_cmd_ctrl_if.sv
// Byte-strobe input, command handshake, payload read port and error pulses
// of the UART command-frame controller.
interface uart_cmd_if #(
    parameter int ADDR_W = 4
);
    logic                             rx_ready;
    logic [uart_cmd_pkg::BYTE_W-1:0]  rx_data;
    logic                             cmd_valid;
    logic [uart_cmd_pkg::BYTE_W-1:0]  cmd_code;
    logic [uart_cmd_pkg::BYTE_W-1:0]  cmd_len;
    logic                             cmd_ack;
    logic [ADDR_W-1:0]                pl_addr;
    logic [uart_cmd_pkg::BYTE_W-1:0]  pl_data;
    logic                             err_chk;
    logic                             err_len;
    logic                             err_timeout;
    logic                             err_overrun;
    logic                             busy;

    // Application / receiver side.
    modport master (
        output rx_ready, rx_data, cmd_ack, pl_addr,
        input  cmd_valid, cmd_code, cmd_len, pl_data,
        input  err_chk, err_len, err_timeout, err_overrun, busy
    );

    // Controller side.
    modport slave (
        input  rx_ready, rx_data, cmd_ack, pl_addr,
        output cmd_valid, cmd_code, cmd_len, pl_data,
        output err_chk, err_len, err_timeout, err_overrun, busy
    );
endinterface

// File: rtl/uart_cmd_ctrl_buf.sv
// Payload buffer: DEPTH x 8 register array, synchronous write and
// combinational read. Contents are deliberately not reset.
module uart_cmd_buf #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [7:0]        wr_data_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [7:0]        rd_data_o
);
    logic [7:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Addresses past DEPTH (non power-of-two depths) read as zero.
    assign rd_data_o = (int'(rd_addr_i) < DEPTH) ? mem_q[rd_addr_i] : 8'h00;

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Command-frame controller behind the UART receiver. Inter-byte timeout is
// built only when UART_CMD_TIMEOUT_EN is defined; otherwise err_timeout is 0.
module uart_cmd_ctrl
    import uart_cmd_pkg::*;
#(
    parameter logic [BYTE_W-1:0] SOF_BYTE       = SOF_DEFAULT,
    parameter int                MAX_LEN        = 16,
    parameter int                TIMEOUT_CYCLES = 20000,
    localparam int               ADDR_W         = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
    input logic       clk,
    input logic       rst_n,
    uart_cmd_if.slave bus
);
    localparam logic [BYTE_W-1:0] MAX_LEN_B = BYTE_W'(MAX_LEN);

    if (MAX_LEN < 1 || MAX_LEN > 255 || TIMEOUT_CYCLES < 2) begin : g_badParams
        $error("uart_cmd_ctrl: parameter out of range");
    end

    state_e            state_q, state_d;
    logic [BYTE_W-1:0] code_q, code_d;
    logic [BYTE_W-1:0] len_q, len_d;
    logic [BYTE_W-1:0] idx_q, idx_d;
    logic [BYTE_W-1:0] chkAcc_q, chkAcc_d;
    logic [BYTE_W-1:0] cmdCode_q, cmdCode_d;
    logic [BYTE_W-1:0] cmdLen_q, cmdLen_d;
    logic              errChk_q, errChk_d;
    logic              errLen_q, errLen_d;
    logic              errTimeout_q, errTimeout_d;
    logic              errOverrun_q, errOverrun_d;
    logic              bufWrEn;
    logic              tmoExpired;
    logic [BYTE_W-1:0] idxNext;

    assign idxNext = idx_q + 8'd1;

`ifdef UART_CMD_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic             frameActive;
    logic [TMO_W-1:0] tmoCnt_q, tmoCnt_d;

    assign frameActive = state_q inside {ST_CMD, ST_LEN, ST_DATA, ST_CHK};
    // A byte arriving on the expiry cycle wins, so rx_ready masks expiry.
    assign tmoExpired  = frameActive && !bus.rx_ready && (tmoCnt_q == TMO_LAST);

    always_comb begin
        tmoCnt_d = tmoCnt_q + 1'b1;
        if (!frameActive || bus.rx_ready || tmoExpired) begin
            tmoCnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tmoCnt_q <= '0;
        end else begin
            tmoCnt_q <= tmoCnt_d;
        end
    end
`else
    assign tmoExpired = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        code_d       = code_q;
        len_d        = len_q;
        idx_d        = idx_q;
        chkAcc_d     = chkAcc_q;
        cmdCode_d    = cmdCode_q;
        cmdLen_d     = cmdLen_q;
        errChk_d     = 1'b0;
        errLen_d     = 1'b0;
        errTimeout_d = 1'b0;
        errOverrun_d = 1'b0;
        bufWrEn      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.rx_ready && bus.rx_data == SOF_BYTE) begin
                    state_d = ST_CMD;
                end
            end
            ST_CMD: begin
                if (bus.rx_ready) begin
                    code_d   = bus.rx_data;
                    chkAcc_d = bus.rx_data;
                    state_d  = ST_LEN;
                end
            end
            ST_LEN: begin
                if (bus.rx_ready) begin
                    chkAcc_d = chkAcc_q ^ bus.rx_data;
                    len_d    = bus.rx_data;
                    idx_d    = '0;
                    if (bus.rx_data > MAX_LEN_B) begin
                        errLen_d = 1'b1;
                        state_d  = ST_IDLE;
                    end else if (bus.rx_data == '0) begin
                        state_d = ST_CHK;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (bus.rx_ready) begin
                    bufWrEn  = 1'b1;
                    chkAcc_d = chkAcc_q ^ bus.rx_data;
                    idx_d    = idxNext;
                    if (idxNext == len_q) begin
                        state_d = ST_CHK;
                    end
                end
            end
            ST_CHK: begin
                if (bus.rx_ready) begin
                    if (bus.rx_data == chkAcc_q) begin
                        cmdCode_d = code_q;
                        cmdLen_d  = len_q;
                        state_d   = ST_HOLD;
                    end else begin
                        errChk_d = 1'b1;
                        state_d  = ST_IDLE;
                    end
                end
            end
            ST_HOLD: begin
                // Bytes arriving while the command is held are dropped, even alongside an ack.
                if (bus.rx_ready) begin
                    errOverrun_d = 1'b1;
                end
                if (bus.cmd_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (tmoExpired) begin
            state_d      = ST_IDLE;
            errTimeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            code_q       <= '0;
            len_q        <= '0;
            idx_q        <= '0;
            chkAcc_q     <= '0;
            cmdCode_q    <= '0;
            cmdLen_q     <= '0;
            errChk_q     <= 1'b0;
            errLen_q     <= 1'b0;
            errTimeout_q <= 1'b0;
            errOverrun_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            code_q       <= code_d;
            len_q        <= len_d;
            idx_q        <= idx_d;
            chkAcc_q     <= chkAcc_d;
            cmdCode_q    <= cmdCode_d;
            cmdLen_q     <= cmdLen_d;
            errChk_q     <= errChk_d;
            errLen_q     <= errLen_d;
            errTimeout_q <= errTimeout_d;
            errOverrun_q <= errOverrun_d;
        end
    end

    uart_cmd_buf #(
        .DEPTH  (MAX_LEN),
        .ADDR_W (ADDR_W)
    ) u_buf (
        .clk       (clk),
        .wr_en_i   (bufWrEn),
        .wr_addr_i (idx_q[ADDR_W-1:0]),
        .wr_data_i (bus.rx_data),
        .rd_addr_i (bus.pl_addr),
        .rd_data_o (bus.pl_data)
    );

    assign bus.cmd_valid   = (state_q == ST_HOLD);
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.cmd_code    = cmdCode_q;
    assign bus.cmd_len     = cmdLen_q;
    assign bus.err_chk     = errChk_q;
    assign bus.err_len     = errLen_q;
    assign bus.err_timeout = errTimeout_q;
    assign bus.err_overrun = errOverrun_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Scoreboard bench for uart_cmd_ctrl: a queue-based frame model predicts
// accepts and error pulses; a monitor pops and compares as the DUT reports.
module tb_uart_cmd_ctrl;
    localparam int         MAX_LEN = 16;
    localparam int         TMO     = 64;
    localparam int         ADDR_W  = 4;
    localparam logic [7:0] SOF     = 8'hA5;

    typedef enum int {EV_ACCEPT, EV_CHK, EV_LEN, EV_TIMEOUT, EV_OVERRUN} evKind_e;
    typedef struct {
        evKind_e    kind;
        int         cyc;
        logic [7:0] code;
        logic [7:0] len;
    } expEvent_t;

    logic clk;
    logic rst_n;

    uart_cmd_if #(.ADDR_W(ADDR_W)) bus();

    uart_cmd_ctrl #(
        .SOF_BYTE       (SOF),
        .MAX_LEN        (MAX_LEN),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int         vectors     = 0;
    int         miscompares = 0;
    int         cyc         = 0;
    expEvent_t  expQ[$];
    logic [7:0] frame[$];
    logic [7:0] lastPayload[$];
    bit         holding     = 0;
    int         silent      = 0;
    logic [7:0] expCode     = 8'h00;
    logic [7:0] expLen      = 8'h00;
    bit         expBusy     = 0;
    bit         prevValid   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void pushEv(input evKind_e kind, input logic [7:0] code, input logic [7:0] len);
        expEvent_t e;
        e.kind = kind;
        e.cyc  = cyc;
        e.code = code;
        e.len  = len;
        expQ.push_back(e);
    endfunction

    // Frame judged from byte count in the collected queue, not from a state walk.
    function automatic void judgeFrame();
        int         n;
        logic [7:0] sum;
        n = frame.size();
        if (n == 3 && frame[2] > MAX_LEN) begin
            pushEv(EV_LEN, 8'h00, 8'h00);
            frame.delete();
        end else if (n >= 4 && n == int'(frame[2]) + 4) begin
            sum = 8'h00;
            for (int i = 1; i < n - 1; i++) sum ^= frame[i];
            if (sum == frame[n-1]) begin
                holding = 1;
                expCode = frame[1];
                expLen  = frame[2];
                lastPayload.delete();
                for (int i = 3; i < n - 1; i++) lastPayload.push_back(frame[i]);
                pushEv(EV_ACCEPT, frame[1], frame[2]);
            end else begin
                pushEv(EV_CHK, 8'h00, 8'h00);
            end
            frame.delete();
        end
    endfunction

    // Reference model: advances on every clock edge from the bench's own stimulus.
    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            frame.delete();
            holding = 0;
            silent  = 0;
            expCode = 8'h00;
            expLen  = 8'h00;
        end else if (holding) begin
            if (bus.rx_ready) pushEv(EV_OVERRUN, 8'h00, 8'h00);
            if (bus.cmd_ack) holding = 0;
        end else if (frame.size() == 0) begin
            if (bus.rx_ready && bus.rx_data == SOF) begin
                frame.push_back(SOF);
                silent = 0;
            end
        end else if (bus.rx_ready) begin
            frame.push_back(bus.rx_data);
            silent = 0;
            judgeFrame();
        end else begin
`ifdef UART_CMD_TIMEOUT_EN
            silent++;
            if (silent >= TMO) begin
                pushEv(EV_TIMEOUT, 8'h00, 8'h00);
                frame.delete();
            end
`endif
        end
        expBusy = holding || (frame.size() != 0);
    end

    task automatic popCheck(input evKind_e kind);
        expEvent_t e;
        vectors++;
        if (expQ.size() == 0) begin
            miscompares++;
            $display("[TB] FAIL event %s: DUT reported it, none expected (cycle %0d)", kind.name(), cyc);
        end else begin
            e = expQ.pop_front();
            if (e.kind != kind || e.cyc != cyc ||
                (kind == EV_ACCEPT && (e.code !== bus.cmd_code || e.len !== bus.cmd_len))) begin
                miscompares++;
                $display("[TB] FAIL event: got %s cyc=%0d code=%0h len=%0h, expected %s cyc=%0d code=%0h len=%0h",
                         kind.name(), cyc, bus.cmd_code, bus.cmd_len, e.kind.name(), e.cyc, e.code, e.len);
            end
        end
    endtask

    // Monitor: levels every cycle, events whenever the DUT presents them.
    always @(posedge clk) begin
        #1;
        cmp("busy", bus.busy, expBusy);
        cmp("cmd_valid", bus.cmd_valid, holding);
        cmp("cmd_code", bus.cmd_code, expCode);
        cmp("cmd_len", bus.cmd_len, expLen);
        if (bus.cmd_valid === 1'b1 && !prevValid) popCheck(EV_ACCEPT);
        if (bus.err_chk === 1'b1)     popCheck(EV_CHK);
        if (bus.err_len === 1'b1)     popCheck(EV_LEN);
        if (bus.err_timeout === 1'b1) popCheck(EV_TIMEOUT);
        if (bus.err_overrun === 1'b1) popCheck(EV_OVERRUN);
        while (expQ.size() != 0 && expQ[0].cyc <= cyc) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL event %s: expected at cycle %0d, not reported", expQ[0].kind.name(), expQ[0].cyc);
            void'(expQ.pop_front());
        end
        prevValid = (bus.cmd_valid === 1'b1);
    end

    // One byte strobe; called and returns at a falling edge.
    task automatic applyStimulus(input logic [7:0] b, input int gap);
        bus.rx_ready = 1'b1;
        bus.rx_data  = b;
        @(negedge clk);
        bus.rx_ready = 1'b0;
        bus.rx_data  = 8'($urandom);
        repeat (gap) @(negedge clk);
    endtask

    task automatic sendBytes(input logic [7:0] bs[$]);
        foreach (bs[i]) applyStimulus(bs[i], 0);
    endtask

    task automatic sendFrame(input logic [7:0] code, input logic [7:0] len, input logic [7:0] pl[$],
                             input bit corrupt, input int stallIdx);
        logic [7:0] bs[$];
        logic [7:0] sum;
        sum = code ^ len;
        bs  = '{SOF, code, len};
        foreach (pl[i]) begin
            bs.push_back(pl[i]);
            sum ^= pl[i];
        end
        if (corrupt) sum ^= 8'($urandom_range(1, 255));
        if (len <= MAX_LEN) bs.push_back(sum);
        foreach (bs[i]) applyStimulus(bs[i], (i == stallIdx) ? TMO + 3 : $urandom_range(0, 2));
    endtask

    task automatic checkPayload();
        for (int i = 0; i < lastPayload.size(); i++) begin
            bus.pl_addr = ADDR_W'(i);
            #1;
            cmp("pl_data", bus.pl_data, lastPayload[i]);
        end
    endtask

    // Reads back the held command's payload, optionally overruns, then acks.
    task automatic checkOutput(input int ackDelay, input bit overrun, input bit ackWithByte);
        if (!holding) return;
        checkPayload();
        repeat (ackDelay) @(negedge clk);
        if (overrun) begin
            applyStimulus(8'($urandom), 0);
            checkPayload();
        end
        bus.cmd_ack = 1'b1;
        if (ackWithByte) begin
            bus.rx_ready = 1'b1;
            bus.rx_data  = SOF;
        end
        @(negedge clk);
        bus.cmd_ack  = 1'b0;
        bus.rx_ready = 1'b0;
    endtask

    initial begin
        logic [7:0] pl[$];
        logic [7:0] len;
        int         kind;
        rst_n        = 1'b0;
        bus.rx_ready = 1'b0;
        bus.rx_data  = 8'h00;
        bus.cmd_ack  = 1'b0;
        bus.pl_addr  = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Basic frame with two payload bytes.
        sendBytes('{8'hA5, 8'h10, 8'h02, 8'h33, 8'h44, 8'h65});
        cmp("A cmd_valid", bus.cmd_valid, 1'b1);
        cmp("A cmd_code", bus.cmd_code, 8'h10);
        cmp("A cmd_len", bus.cmd_len, 8'h02);
        bus.pl_addr = 4'd0; #1;
        cmp("A pl_data@0", bus.pl_data, 8'h33);
        bus.pl_addr = 4'd1; #1;
        cmp("A pl_data@1", bus.pl_data, 8'h44);
        checkOutput(2, 0, 0);
        cmp("A busy after ack", bus.busy, 1'b0);

        // Empty payload.
        sendBytes('{8'hA5, 8'h20, 8'h00, 8'h20});
        cmp("B cmd_len", bus.cmd_len, 8'h00);
        checkOutput(0, 0, 0);

        // Bad checksum, then a good frame.
        sendBytes('{8'hA5, 8'h10, 8'h02, 8'h33, 8'h44, 8'h00});
        repeat (2) @(negedge clk);
        sendBytes('{8'hA5, 8'h10, 8'h02, 8'h33, 8'h44, 8'h65});
        checkOutput(1, 0, 0);

        // Oversized LEN; trailing bytes ignored.
        sendBytes('{8'hA5, 8'h10, 8'h11, 8'h01, 8'h02});
        repeat (3) @(negedge clk);

        // Stall after CMD.
        sendBytes('{8'hA5, 8'h10});
        repeat (TMO + 5) @(negedge clk);
`ifndef UART_CMD_TIMEOUT_EN
        cmp("stall busy", bus.busy, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
`endif

        // Overrun while held, then ack together with a byte.
        sendBytes('{8'hA5, 8'h10, 8'h02, 8'h33, 8'h44, 8'h65});
        checkOutput(1, 1, 0);
        sendBytes('{8'hA5, 8'h31, 8'h01, 8'hA5, 8'h95});
        checkOutput(0, 0, 1);

        // Reset in the middle of the payload.
        sendBytes('{8'hA5, 8'h10, 8'h02, 8'h33});
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cmp("reset cmd_code", bus.cmd_code, 8'h00);
        cmp("reset busy", bus.busy, 1'b0);

        // Randomized frames.
        for (int it = 0; it < 250; it++) begin
            kind = $urandom_range(0, 9);
            if ($urandom_range(0, 4) == 0) applyStimulus(8'($urandom_range(0, 8'hA4)), $urandom_range(0, 2));
            len = (kind == 0) ? 8'($urandom_range(MAX_LEN + 1, 255)) : 8'($urandom_range(0, MAX_LEN));
            pl.delete();
            if (len <= MAX_LEN) begin
                for (int i = 0; i < int'(len); i++) pl.push_back(($urandom_range(0, 7) == 0) ? SOF : 8'($urandom));
            end
            sendFrame(8'($urandom), len, pl, kind == 1,
                      (kind == 2) ? $urandom_range(0, 2) : -1);
            checkOutput($urandom_range(0, 3), $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        while (expQ.size() != 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL event %s: still pending at end of run", expQ[0].kind.name());
            void'(expQ.pop_front());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
